// File: rtl/line_buffer_ctrl.sv
// Row sequencer for the 10-row line buffer: fetches SRAM rows, inserts Gaussian
// zero padding and hands each complete window to the downstream engine.
module line_buffer_ctrl #(
    parameter int ROW_W         = 10,
    parameter int ADDR_W        = 12,
    parameter int GAUSS_DEPTH   = 6,
    parameter int GAUSS_PAD_TOP = 3,
    parameter int GAUSS_PAD_BOT = 2,
    parameter int DET_DEPTH     = 2,
    parameter int MATCH_DEPTH   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        mode_sel,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              abort,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    output logic [2:0]        buffer_mode,
    output logic              buffer_we,
    output logic              fill_zero,
    output logic              win_valid,
    output logic [ROW_W-1:0]  win_row,
    input  logic              win_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] MODE_GAUSS = 3'd1;
    localparam logic [2:0] MODE_DET   = 3'd2;
    localparam logic [2:0] MODE_MATCH = 3'd3;

    typedef enum logic [2:0] {IDLE, PAD_TOP, FETCH, WAIT, EMIT, PAD_BOT, DONE} state_t;

    state_t state, state_d;

    logic [2:0]        mode_q;
    logic [ROW_W-1:0]  num_q;
    logic [ADDR_W-1:0] base_q;
    logic [ROW_W-1:0]  shift_cnt, fetch_idx, win_cnt, bot_cnt;
    logic [ROW_W-1:0]  depth, win_total, win_nxt;
    logic [ROW_W:0]    shift_nxt, fetch_nxt;
    logic              is_gauss, start_ok, start_empty;
    logic              accept, shift_en, fetch_en, win_en, bot_en;

    assign is_gauss  = (mode_q == MODE_GAUSS);
    assign shift_nxt = {1'b0, shift_cnt} + (ROW_W+1)'(1);
    assign fetch_nxt = {1'b0, fetch_idx} + (ROW_W+1)'(1);
    assign win_nxt   = win_cnt + ROW_W'(1);
    assign start_ok  = start && (mode_sel == MODE_GAUSS || mode_sel == MODE_DET ||
                                 mode_sel == MODE_MATCH);

    always_comb begin
        depth     = '0;
        win_total = '0;
        case (mode_q)
            MODE_GAUSS: begin depth = ROW_W'(GAUSS_DEPTH); win_total = num_q;               end
            MODE_DET:   begin depth = ROW_W'(DET_DEPTH);   win_total = num_q - ROW_W'(1);   end
            MODE_MATCH: begin depth = ROW_W'(MATCH_DEPTH); win_total = num_q - ROW_W'(2);   end
            default:    ;
        endcase
    end

    // Window count would be <= 0: compared on num_rows directly so it cannot underflow.
    always_comb begin
        case (mode_sel)
            MODE_GAUSS: start_empty = (num_rows == '0);
            MODE_DET:   start_empty = (num_rows < ROW_W'(2));
            MODE_MATCH: start_empty = (num_rows < ROW_W'(3));
            default:    start_empty = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state;
        rd_req    = 1'b0;
        buffer_we = 1'b0;
        fill_zero = 1'b0;
        win_valid = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        shift_en  = 1'b0;
        fetch_en  = 1'b0;
        win_en    = 1'b0;
        bot_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    accept = 1'b1;
                    if (start_empty)              state_d = DONE;
                    else if (mode_sel == MODE_GAUSS) state_d = PAD_TOP;
                    else                          state_d = FETCH;
                end
            end
            PAD_TOP: begin
                fill_zero = 1'b1;
                buffer_we = 1'b1;
                shift_en  = 1'b1;
                if (shift_nxt >= (ROW_W+1)'(GAUSS_PAD_TOP)) state_d = FETCH;
            end
            FETCH: begin
                rd_req  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (rd_valid) begin
                    buffer_we = 1'b1;
                    shift_en  = 1'b1;
                    fetch_en  = 1'b1;
                    if (shift_nxt >= {1'b0, depth})     state_d = EMIT;
                    else if (fetch_nxt < {1'b0, num_q}) state_d = FETCH;
                    else if (is_gauss)                  state_d = PAD_BOT;
                    else                                state_d = DONE;
                end
            end
            EMIT: begin
                win_valid = 1'b1;
                if (win_ready) begin
                    win_en = 1'b1;
                    if (win_nxt == win_total)                           state_d = DONE;
                    else if (fetch_idx < num_q)                         state_d = FETCH;
                    else if (is_gauss && bot_cnt < ROW_W'(GAUSS_PAD_BOT)) state_d = PAD_BOT;
                    else                                                state_d = DONE;
                end
            end
            PAD_BOT: begin
                fill_zero = 1'b1;
                buffer_we = 1'b1;
                shift_en  = 1'b1;
                bot_en    = 1'b1;
                state_d   = EMIT;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over any shift, read or window handshake in the same cycle.
        if (abort && state != IDLE) begin
            state_d   = IDLE;
            rd_req    = 1'b0;
            buffer_we = 1'b0;
            fill_zero = 1'b0;
            done      = 1'b0;
            shift_en  = 1'b0;
            fetch_en  = 1'b0;
            win_en    = 1'b0;
            bot_en    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= '0;
            num_q     <= '0;
            base_q    <= '0;
            shift_cnt <= '0;
            fetch_idx <= '0;
            win_cnt   <= '0;
            bot_cnt   <= '0;
        end else if (accept) begin
            mode_q    <= mode_sel;
            num_q     <= num_rows;
            base_q    <= base_addr;
            shift_cnt <= '0;
            fetch_idx <= '0;
            win_cnt   <= '0;
            bot_cnt   <= '0;
        end else begin
            // Only the >= depth threshold matters, so saturate instead of wrapping on long runs.
            if (shift_en && shift_cnt != '1) shift_cnt <= shift_cnt + ROW_W'(1);
            if (fetch_en) fetch_idx <= fetch_idx + ROW_W'(1);
            if (win_en)   win_cnt   <= win_nxt;
            if (bot_en)   bot_cnt   <= bot_cnt + ROW_W'(1);
        end
    end

    assign rd_addr     = base_q + ADDR_W'(fetch_idx);
    assign buffer_mode = (state == IDLE) ? '0 : mode_q;
    assign win_row     = win_valid ? win_cnt : '0;
    assign busy        = (state != IDLE);

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
Sequencer for the 10-row line buffer. Per run it drives buffer_mode, buffer_we and fill_zero. It fetches one 5120-bit row per SRAM read transaction, inserts zero padding rows for Gaussian mode, and announces each complete row window to the downstream engine. The downstream engine can stall the sequencer with backpressure. Sits between the top-level system FSM, the row SRAM read port and the line buffer / Gaussian / detect / match engines.

Parameters:
ROW_W, 10, width of row counters and num_rows
ADDR_W, 12, SRAM row address width
GAUSS_DEPTH, 6, Gaussian window height in rows
GAUSS_PAD_TOP, 3, zero rows shifted in before the first image row (Gaussian)
GAUSS_PAD_BOT, 2, zero rows shifted in after the last image row (Gaussian)
DET_DEPTH, 2, detect/filter window height
MATCH_DEPTH, 3, compute-match window height

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  one-cycle run request; sampled only in IDLE
mode_sel  in  3  1=GAUSSIAN, 2=DETECT_FILTER, 3=COMPUTE_MATCH; other values ignore start
num_rows  in  ROW_W  image rows in this run; sampled with start
base_addr  in  ADDR_W  SRAM address of row 0; sampled with start
abort  in  1  synchronous abandon of the current run
rd_req  out  1  one-cycle SRAM row read request
rd_addr  out  ADDR_W  base_addr + fetch index; valid with rd_req
rd_valid  in  1  SRAM row data valid (img/in/blur buses) this cycle
buffer_mode  out  3  to line buffer; 0 in IDLE, latched mode_sel otherwise
buffer_we  out  1  line buffer shift enable
fill_zero  out  1  shift a zero row instead of SRAM data (Gaussian only)
win_valid  out  1  buffer window complete and stable
win_row  out  ROW_W  output row index of the current window, 0-based
win_ready  in  1  downstream consumed the window
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset mid-run gives the same result; buffer_mode=0 clears the line buffer on the next edge.
- States: IDLE, PAD_TOP, FETCH, WAIT, EMIT, PAD_BOT, DONE.
- IDLE: on start with mode_sel in 1..3, latch mode/num_rows/base_addr; shift_cnt=0, fetch_idx=0, win_cnt=0.
  - Gaussian goes to PAD_TOP; other modes go to FETCH.
  - Depth D = GAUSS_DEPTH / DET_DEPTH / MATCH_DEPTH per mode.
  - Expected windows W: Gaussian W=num_rows; detect W=num_rows-1; match W=num_rows-2.
  - If W<=0 (underflow-safe compare), go straight to DONE with no reads.
- PAD_TOP: one cycle per pad row, fill_zero=1 and buffer_we=1, shift_cnt++. After GAUSS_PAD_TOP cycles, go to FETCH.
- FETCH: rd_req=1 for exactly one cycle, rd_addr=base_addr+fetch_idx; go to WAIT. At most one read outstanding.
- WAIT: buffer_we = rd_valid (combinational, same cycle, so the buffer captures the data on that edge). fill_zero=0. On rd_valid: shift_cnt++, fetch_idx++.
  - If shift_cnt (post-increment) >= D, go to EMIT.
  - Else if fetch_idx<num_rows, go to FETCH.
  - Else go to PAD_BOT (Gaussian) or DONE.
- rd_valid outside WAIT is ignored; no shift occurs.
- EMIT: win_valid=1, win_row=win_cnt. buffer_we=0 while in EMIT, so the window holds stable. Exit on win_valid && win_ready: win_cnt++.
  - win_cnt==W goes to DONE.
  - Else fetch_idx<num_rows goes to FETCH.
  - Else go to PAD_BOT (Gaussian only).
- PAD_BOT: one cycle, fill_zero=1, buffer_we=1, shift_cnt++, then EMIT. Pad rows used never exceed GAUSS_PAD_BOT.
- DONE: done=1 for one cycle, busy still 1; next state IDLE, where buffer_mode returns to 0.
- abort in any non-IDLE state: next state IDLE, no done pulse. An outstanding read's rd_valid is then ignored.
- start while busy is ignored. abort has priority over rd_valid/win_ready in the same cycle.
- Counter widths: ROW_W; fetch_idx never exceeds num_rows; rd_addr addition wraps modulo 2^ADDR_W.

Test Plan:
- Gaussian, num_rows=4, base=0x100, rd_valid 2 cycles after rd_req, win_ready=1:
  - 3 fill_zero shifts, then reads 0x100..0x103, then 2 bottom pads.
  - win_valid for win_row 0..3 (first after 3 pads + 3 rows).
  - Exactly 4 windows, done once, buffer_mode=1 throughout, then 0.
- Detect, num_rows=3, win_ready held low 5 cycles on first window:
  - buffer_we stays 0 and no rd_req while stalled; win_row 0 then 1; 2 windows; fill_zero never asserted.
- Match, num_rows=2: start → DONE with no rd_req, done pulse next cycle.
- Match, num_rows=5, base=0xFFE: rd_addr sequence 0xFFE, 0xFFF, 0x000, 0x001, 0x002; windows 0..2.
- abort during WAIT of Gaussian row 2, then late rd_valid: no buffer_we, no done, buffer_mode=0 next cycle, busy=0. A new start runs cleanly.
- start with mode_sel=0 or 5, and start while busy: no state change, no rd_req.
